// File: rtl/skewed_operand_feeder.sv
// Double-buffered operand feeder for one systolic-mesh edge: ping-pong tile banks
// written lane-major, replayed as a diagonal wavefront (lane l delayed l cycles).
module skewed_operand_feeder #(
   parameter int LANES      = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                             clk_i,
   input  logic                             rstn_i,
   input  logic                             flush_i,
   input  logic [$clog2(DEPTH+1)-1:0]       cfg_k_i,
   input  logic                             wr_valid_i,
   output logic                             wr_ready_o,
   input  logic [DATA_WIDTH-1:0]            wr_data_i,
   input  logic                             start_i,
   input  logic                             stall_i,
   output logic [LANES-1:0][DATA_WIDTH-1:0] data_o,
   output logic [LANES-1:0]                 valid_o,
   output logic [LANES-1:0]                 last_o,
   output logic                             busy_o,
   output logic                             done_o,
   output logic                             tile_ready_o,
   output logic                             cfg_err_o
);

   localparam int KW    = $clog2(DEPTH + 1);
   localparam int TW    = $clog2(DEPTH + LANES);
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int WORDS = LANES * DEPTH;
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [1:0] B_EMPTY    = 2'd0;
   localparam logic [1:0] B_FILLING  = 2'd1;
   localparam logic [1:0] B_FULL     = 2'd2;
   localparam logic [1:0] B_DRAINING = 2'd3;

   localparam logic [0:0] RD_IDLE = 1'b0;
   localparam logic [0:0] RD_RUN  = 1'b1;

   logic [1:0][1:0]                 bank_st_q, bank_st_d;
   logic [1:0][KW-1:0]              bank_k_q, bank_k_d;
   logic                            wb_q, wb_d;
   logic                            rb_q, rb_d;
   logic [LW-1:0]                   wr_lane_q, wr_lane_d;
   logic [KW-1:0]                   wr_k_q, wr_k_d;
   logic [0:0]                      rd_st_q, rd_st_d;
   logic [TW-1:0]                   t_q, t_d;
   logic [LANES-1:0][DATA_WIDTH-1:0] data_q, data_d;
   logic [LANES-1:0]                valid_q, valid_d;
   logic [LANES-1:0]                last_q, last_d;
   logic                            done_q, done_d;
   logic                            cfg_err_q, cfg_err_d;

   logic [DATA_WIDTH-1:0]           mem_q [2][WORDS];

   logic                            wr_fire;
   logic                            cfg_ok;
   logic [KW-1:0]                   cfg_clamped;
   logic [KW-1:0]                   wr_k_eff;
   logic                            wr_last_beat;
   logic [AW-1:0]                   wr_addr;
   logic [KW-1:0]                   rd_k;
   int                              t_max;
   logic                            start_ok;

   assign wr_ready_o   = (bank_st_q[wb_q] == B_EMPTY) || (bank_st_q[wb_q] == B_FILLING);
   assign wr_fire      = wr_valid_i && wr_ready_o && !flush_i;
   assign cfg_ok       = (cfg_k_i != '0) && (cfg_k_i <= KW'(DEPTH));
   assign cfg_clamped  = cfg_ok ? cfg_k_i : KW'(DEPTH);
   // K for the beat in flight: the live config on a bank's first beat, the latched one afterwards
   assign wr_k_eff     = (bank_st_q[wb_q] == B_EMPTY) ? cfg_clamped : bank_k_q[wb_q];
   assign wr_last_beat = (wr_lane_q == LW'(LANES - 1)) && (wr_k_q == wr_k_eff - KW'(1));
   assign wr_addr      = AW'(int'(wr_lane_q) * DEPTH + int'(wr_k_q));

   assign rd_k     = bank_k_q[rb_q];
   assign t_max    = int'(rd_k) + LANES - 2;
   assign start_ok = start_i && (rd_st_q == RD_IDLE) && !done_q && (bank_st_q[rb_q] == B_FULL);

   always_comb begin
      int  tt;
      logic load_out;
      bank_st_d = bank_st_q;
      bank_k_d  = bank_k_q;
      wb_d      = wb_q;
      rb_d      = rb_q;
      wr_lane_d = wr_lane_q;
      wr_k_d    = wr_k_q;
      rd_st_d   = rd_st_q;
      t_d       = t_q;
      data_d    = data_q;
      valid_d   = valid_q;
      last_d    = last_q;
      done_d    = 1'b0;
      cfg_err_d = cfg_err_q;
      load_out  = 1'b0;
      tt        = 0;

      if (rd_st_q == RD_RUN) begin
         if (!stall_i) begin
            if (int'(t_q) == t_max) begin
               done_d          = 1'b1;
               rd_st_d         = RD_IDLE;
               t_d             = '0;
               data_d          = '0;
               valid_d         = '0;
               last_d          = '0;
               bank_st_d[rb_q] = B_EMPTY;
               rb_d            = ~rb_q;
            end else begin
               t_d      = t_q + TW'(1);
               load_out = 1'b1;
            end
         end
      end else if (start_ok) begin
         rd_st_d         = RD_RUN;
         t_d             = '0;
         bank_st_d[rb_q] = B_DRAINING;
         load_out        = 1'b1;
      end

      // Outputs are registered, so they are computed from the next wavefront position
      if (load_out) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            tt         = int'(t_d) - int'(l);
            valid_d[l] = 1'b0;
            data_d[l]  = '0;
            last_d[l]  = 1'b0;
            if (tt >= 0 && tt < int'(rd_k)) begin
               valid_d[l] = 1'b1;
               data_d[l]  = mem_q[rb_q][AW'(int'(l) * DEPTH + tt)];
               last_d[l]  = (tt == int'(rd_k) - 1);
            end
         end
      end

      if (wr_fire) begin
         if (bank_st_q[wb_q] == B_EMPTY) begin
            bank_k_d[wb_q]  = cfg_clamped;
            bank_st_d[wb_q] = B_FILLING;
            if (!cfg_ok) cfg_err_d = 1'b1;
         end
         if (wr_last_beat) begin
            bank_st_d[wb_q] = B_FULL;
            wb_d            = ~wb_q;
            wr_lane_d       = '0;
            wr_k_d          = '0;
         end else if (wr_k_q == wr_k_eff - KW'(1)) begin
            wr_k_d    = '0;
            wr_lane_d = wr_lane_q + LW'(1);
         end else begin
            wr_k_d = wr_k_q + KW'(1);
         end
      end

      if (flush_i) begin
         bank_st_d[0] = B_EMPTY;
         bank_st_d[1] = B_EMPTY;
         bank_k_d     = '0;
         wb_d         = 1'b0;
         rb_d         = 1'b0;
         wr_lane_d    = '0;
         wr_k_d       = '0;
         rd_st_d      = RD_IDLE;
         t_d          = '0;
         data_d       = '0;
         valid_d      = '0;
         last_d       = '0;
         done_d       = 1'b0;
         cfg_err_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         bank_st_q <= '0;
         bank_k_q  <= '0;
         wb_q      <= 1'b0;
         rb_q      <= 1'b0;
         wr_lane_q <= '0;
         wr_k_q    <= '0;
         rd_st_q   <= RD_IDLE;
         t_q       <= '0;
         data_q    <= '0;
         valid_q   <= '0;
         last_q    <= '0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         bank_st_q <= bank_st_d;
         bank_k_q  <= bank_k_d;
         wb_q      <= wb_d;
         rb_q      <= rb_d;
         wr_lane_q <= wr_lane_d;
         wr_k_q    <= wr_k_d;
         rd_st_q   <= rd_st_d;
         t_q       <= t_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_fire) mem_q[wb_q][wr_addr] <= wr_data_i;
   end

   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign last_o       = last_q;
   assign done_o       = done_q;
   assign cfg_err_o    = cfg_err_q;
   assign busy_o       = (rd_st_q == RD_RUN);
   assign tile_ready_o = (bank_st_q[0] == B_FULL) || (bank_st_q[1] == B_FULL);

endmodule

// File: tb/tb_skewed_operand_feeder.sv
// Bench for skewed_operand_feeder: directed tables/sequences plus a queue-based
// tile model checked every cycle against random traffic.
module tb_skewed_operand_feeder;

   localparam int L  = 4;
   localparam int DW = 8;
   localparam int D  = 4;

   logic                   clk_i = 1'b0;
   logic                   rstn_i = 1'b0;
   logic                   flush_i = 1'b0;
   logic [2:0]             cfg_k_i = '0;
   logic                   wr_valid_i = 1'b0;
   logic                   wr_ready_o;
   logic [DW-1:0]          wr_data_i = '0;
   logic                   start_i = 1'b0;
   logic                   stall_i = 1'b0;
   logic [L-1:0][DW-1:0]   data_o;
   logic [L-1:0]           valid_o;
   logic [L-1:0]           last_o;
   logic                   busy_o;
   logic                   done_o;
   logic                   tile_ready_o;
   logic                   cfg_err_o;

   int checks = 0;
   int errors = 0;

   skewed_operand_feeder #(.LANES(L), .DATA_WIDTH(DW), .DEPTH(D)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i), .cfg_k_i(cfg_k_i),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
      .start_i(start_i), .stall_i(stall_i), .data_o(data_o), .valid_o(valid_o),
      .last_o(last_o), .busy_o(busy_o), .done_o(done_o),
      .tile_ready_o(tile_ready_o), .cfg_err_o(cfg_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- reference model: tiles as whole objects ----------------
   typedef struct packed {
      logic [2:0]         k;
      logic [15:0][7:0]   d;   // compact lane-major: index lane*k + element
   } tile_t;

   tile_t m_tiles[$];   // held tiles, oldest first; [0] is draining when m_drain
   tile_t m_fill = '0;
   int    m_nfill = 0;
   bit    m_drain = 0;
   int    m_t = 0;
   bit    m_done = 0;
   bit    m_err = 0;

   task automatic model_step();
      bit acc;
      bit nd;
      int k;
      if (!rstn_i || flush_i) begin
         m_tiles.delete();
         m_fill  = '0;
         m_nfill = 0;
         m_drain = 0;
         m_t     = 0;
         m_done  = 0;
         m_err   = 0;
      end else begin
         acc = wr_valid_i && (m_tiles.size() < 2);
         nd  = 0;
         if (m_drain) begin
            if (!stall_i) begin
               if (m_t == int'(m_tiles[0].k) + L - 2) begin
                  m_drain = 0;
                  nd      = 1;
                  void'(m_tiles.pop_front());
               end else begin
                  m_t++;
               end
            end
         end else if (start_i && !m_done && m_tiles.size() > 0) begin
            m_drain = 1;
            m_t     = 0;
         end
         m_done = nd;
         if (acc) begin
            if (m_nfill == 0) begin
               k = int'(cfg_k_i);
               if (k == 0 || k > D) begin
                  k     = D;
                  m_err = 1;
               end
               m_fill.k = 3'(k);
            end
            m_fill.d[m_nfill] = wr_data_i;
            m_nfill++;
            if (m_nfill == L * int'(m_fill.k)) begin
               m_tiles.push_back(m_fill);
               m_fill  = '0;
               m_nfill = 0;
            end
         end
      end
   endtask

   task automatic model_compare();
      logic [L-1:0]         ev;
      logic [L-1:0]         el;
      logic [L-1:0][DW-1:0] ed;
      int tt;
      int k;
      ev = '0;
      el = '0;
      ed = '0;
      if (m_drain) begin
         k = int'(m_tiles[0].k);
         for (int l = 0; l < L; l++) begin
            tt = m_t - l;
            if (tt >= 0 && tt < k) begin
               ev[l] = 1'b1;
               ed[l] = m_tiles[0].d[l * k + tt];
               el[l] = (tt == k - 1);
            end
         end
      end
      chk("m_data", data_o, ed);
      chk("m_valid", valid_o, ev);
      chk("m_last", last_o, el);
      chk("m_done", done_o, m_done);
      chk("m_busy", busy_o, m_drain);
      chk("m_tile_ready", tile_ready_o, (m_tiles.size() - int'(m_drain)) > 0);
      chk("m_wr_ready", wr_ready_o, m_tiles.size() < 2);
      chk("m_cfg_err", cfg_err_o, m_err);
   endtask

   initial forever begin
      @(posedge clk_i);
      model_step();
   end

   initial forever begin
      @(negedge clk_i);
      if (rstn_i) model_compare();
   end

   // ---------------- directed helpers ----------------
   task automatic write_beats(input int n, input logic [7:0] base, input logic [2:0] kc,
                              input bit expect_ready);
      int g;
      for (int i = 0; i < n; i++) begin
         g = 0;
         if (expect_ready) chk("pp_wr_ready", wr_ready_o, 1);
         while (!wr_ready_o && g < 64) begin
            step();
            g++;
         end
         if (!wr_ready_o) chk("wr_ready_timeout", wr_ready_o, 1);
         wr_valid_i = 1'b1;
         wr_data_i  = base + 8'(i);
         cfg_k_i    = kc;
         step();
         wr_valid_i = 1'b0;
      end
   endtask

   task automatic wait_done(input string name, input int limit, output int n);
      n = 0;
      while (!done_o && n < limit) begin
         step();
         n++;
      end
      chk(name, done_o, 1);
   endtask

   typedef struct {
      logic         stall;
      logic [L-1:0] valid;
      logic [L-1:0] last;
      logic         done;
      logic [31:0]  data;
   } vec_t;

   vec_t vec[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] snap;

      // K=4 tile 0x00..0x0F; row i = cycle c+1+i after start at c
      vec[0] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 32'h0000_0000};
      vec[1] = '{1'b0, 4'b0011, 4'b0000, 1'b0, 32'h0000_0401};
      vec[2] = '{1'b0, 4'b0111, 4'b0000, 1'b0, 32'h0008_0502};
      vec[3] = '{1'b0, 4'b1111, 4'b0001, 1'b0, 32'h0C09_0603};
      vec[4] = '{1'b0, 4'b1110, 4'b0010, 1'b0, 32'h0D0A_0700};
      vec[5] = '{1'b0, 4'b1100, 4'b0100, 1'b0, 32'h0E0B_0000};
      vec[6] = '{1'b0, 4'b1000, 4'b1000, 1'b0, 32'h0F00_0000};
      vec[7] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0000_0000};

      repeat (3) @(posedge clk_i);
      #1 rstn_i = 1'b1;
      chk("rst_valid", valid_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_wr_ready", wr_ready_o, 1);
      chk("rst_tile_ready", tile_ready_o, 0);
      chk("rst_busy", busy_o, 0);

      // single tile
      write_beats(16, 8'h00, 3'd4, 1'b0);
      chk("st_tile_ready", tile_ready_o, 1);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         stall_i = vec[i].stall;
         chk("tbl_valid", valid_o, vec[i].valid);
         chk("tbl_last", last_o, vec[i].last);
         chk("tbl_done", done_o, vec[i].done);
         chk("tbl_data", data_o, vec[i].data);
         step();
      end
      chk("tbl_idle", busy_o, 0);

      // ping-pong: B loads while A drains
      write_beats(16, 8'h80, 3'd4, 1'b0);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      write_beats(16, 8'h90, 3'd4, 1'b1);
      chk("pp_tile_ready", tile_ready_o, 1);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("pp_busy", busy_o, 1);
      wait_done("pp_done", 20, n);
      step();

      // backfill: both banks full
      write_beats(32, 8'hA0, 3'd4, 1'b0);
      chk("bf_wr_ready", wr_ready_o, 0);
      chk("bf_tile_ready", tile_ready_o, 1);
      wr_valid_i = 1'b1;
      wr_data_i  = 8'hEE;
      step();
      step();
      wr_valid_i = 1'b0;
      chk("bf_17th_blocked", wr_ready_o, 0);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      n = 0;
      while (!done_o && n < 20) begin
         chk("bf_ready_hold", wr_ready_o, 0);
         step();
         n++;
      end
      chk("bf_done", done_o, 1);
      step();
      chk("bf_ready_after_done", wr_ready_o, 1);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      wait_done("bf_done2", 20, n);
      step();

      // stall with K=2
      write_beats(8, 8'h20, 3'd2, 1'b0);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      snap = 32'h0000_2221;
      chk("stl_pre_data", data_o, snap);
      chk("stl_pre_valid", valid_o, 4'b0011);
      chk("stl_pre_last", last_o, 4'b0001);
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 2) stall_i = 1'b0;
         chk("stl_hold_data", data_o, snap);
         chk("stl_hold_valid", valid_o, 4'b0011);
         chk("stl_hold_last", last_o, 4'b0001);
      end
      wait_done("stl_done", 20, n);
      chk("stl_done_latency", n, 4);
      step();

      // cfg_k=0 behaves as K=4
      write_beats(16, 8'h40, 3'd0, 1'b0);
      chk("cfg_err", cfg_err_o, 1);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      wait_done("cfg_done", 20, n);
      chk("cfg_done_latency", n, 7);
      step();

      // flush mid-run
      write_beats(16, 8'h60, 3'd4, 1'b0);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      step();
      chk("fl_busy_before", busy_o, 1);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("fl_valid", valid_o, 0);
      chk("fl_busy", busy_o, 0);
      chk("fl_tile_ready", tile_ready_o, 0);
      chk("fl_wr_ready", wr_ready_o, 1);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("fl_start_ignored", busy_o, 0);
      step();
      chk("fl_valid_after", valid_o, 0);

      // random traffic, checked by the model
      for (int i = 0; i < 3000; i++) begin
         wr_valid_i = 1'($urandom_range(0, 1));
         wr_data_i  = 8'($urandom);
         cfg_k_i    = 3'($urandom_range(0, 7));
         start_i    = ($urandom_range(0, 3) == 0);
         stall_i    = ($urandom_range(0, 4) == 0);
         flush_i    = ($urandom_range(0, 199) == 0);
         step();
      end
      wr_valid_i = 1'b0;
      start_i    = 1'b0;
      stall_i    = 1'b0;
      flush_i    = 1'b0;
      repeat (20) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
